// File: rtl/psum_pkg.sv
// rtl/psum_pkg.sv - shared FSM encoding, stage count and lane-slice macro for psum_accumulator
`ifndef PSUM_PKG_SV
`define PSUM_PKG_SV

`define PSUM_LANE(bus, g, w) bus[((g)+1)*(w)-1 -: (w)]

package psum_pkg;
    typedef enum logic [1:0] {
        PS_IDLE = 2'd0,
        PS_RUN  = 2'd1,
        PS_DONE = 2'd2
    } ps_state_t;

    localparam int PSUM_STG = 3;
endpackage

`endif

// File: rtl/psum_lane_add.sv
// rtl/psum_lane_add.sv - one signed psum lane adder; PSUM_SAT_EN selects saturation, otherwise wrap-around
module psum_lane_add #(
    parameter int W_PSUM = 32
) (
    input  logic [W_PSUM-1:0] a,
    input  logic [W_PSUM-1:0] b,
    output logic [W_PSUM-1:0] sum
);
`ifdef PSUM_SAT_EN
    logic [W_PSUM:0] wide;

    assign wide = {a[W_PSUM-1], a} + {b[W_PSUM-1], b};

    // The two top bits disagree only when the signed result left the W_PSUM range
    always_comb begin
        sum = wide[W_PSUM-1:0];
        if (wide[W_PSUM] != wide[W_PSUM-1])
            sum = wide[W_PSUM] ? {1'b1, {(W_PSUM-1){1'b0}}} : {1'b0, {(W_PSUM-1){1'b1}}};
    end
`else
    assign sum = a + b;
`endif
endmodule

// File: rtl/psum_accumulator.sv
// rtl/psum_accumulator.sv - read-modify-write partial-sum engine with S3/S4 forwarding; optional PSUM_SAT_EN
module psum_accumulator
    import psum_pkg::*;
#(
    parameter int W_SIZE    = 9,
    parameter int W_CHANNEL = 9,
    parameter int Tout      = 4,
    parameter int W_PSUM    = 32,
    parameter int BUF_AW    = 16
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   i_start,
    input  logic [W_SIZE-1:0]      cfg_width,
    input  logic [W_SIZE-1:0]      cfg_height,
    input  logic [W_CHANNEL-1:0]   cfg_q_channel,
    input  logic                   i_vld,
    input  logic [W_SIZE-1:0]      i_row,
    input  logic [W_SIZE-1:0]      i_col,
    input  logic [W_CHANNEL-1:0]   i_ci_tile,
    input  logic [Tout*W_PSUM-1:0] i_acc,
    output logic                   o_pb_rd_req,
    output logic [BUF_AW-1:0]      o_pb_rd_addr,
    input  logic [Tout*W_PSUM-1:0] pb_rd_data,
    output logic                   o_pb_wr_en,
    output logic [BUF_AW-1:0]      o_pb_wr_addr,
    output logic [Tout*W_PSUM-1:0] o_pb_wr_data,
    output logic                   o_out_vld,
    output logic [W_SIZE-1:0]      o_out_row,
    output logic [W_SIZE-1:0]      o_out_col,
    output logic [Tout*W_PSUM-1:0] o_out_data,
    output logic                   o_busy,
    output logic                   o_frame_done,
    output logic                   o_err
);
    localparam int DW = Tout * W_PSUM;

    ps_state_t state_q, state_d;

    logic [W_SIZE-1:0]    cfg_w_q, cfg_h_q;
    logic [W_CHANNEL-1:0] cfg_q_q;
    logic [PSUM_STG:0]    stg_vld;   // bit 0 = S1 ... bit PSUM_STG = S4
    logic                 accept, beat_bad, area_bad, err_q;

    logic [BUF_AW-1:0] s1_addr, s2_addr, s3_addr, s4_addr;
    logic [W_SIZE-1:0] s1_row, s1_col, s2_row, s2_col, s3_row, s3_col;
    logic              s1_first, s1_last, s1_final;
    logic              s2_first, s2_last, s2_final;
    logic              s3_last, s3_final;
    logic [DW-1:0]     s1_acc, s2_acc, s3_data, s4_data, operand, sum_all;

    assign accept   = i_vld && (state_q == PS_RUN) && !i_start;
    assign beat_bad = (i_col >= cfg_w_q) || (i_row >= cfg_h_q) || (i_ci_tile >= cfg_q_q);
    assign area_bad = (64'(cfg_width) * 64'(cfg_height)) > (64'd1 << BUF_AW);

    always_comb begin
        state_d = state_q;
        case (state_q)
            PS_IDLE: if (i_start) state_d = PS_RUN;
            PS_RUN: begin
                if (i_start)
                    state_d = PS_RUN;
                else if (stg_vld[2] && s3_final)
                    state_d = PS_DONE;
            end
            PS_DONE: state_d = i_start ? PS_RUN : PS_IDLE;
            default: state_d = PS_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= PS_IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (i_start)
                err_q <= area_bad;
            else if ((i_vld && state_q == PS_IDLE) || (accept && beat_bad))
                err_q <= 1'b1;
        end
    end

    // A first-tile beat overwrites, so it never looks at stored or in-flight data
    always_comb begin
        operand = pb_rd_data;
        if (s2_first)
            operand = '0;
        else if (stg_vld[2] && s3_addr == s2_addr)
            operand = s3_data;
        else if (stg_vld[3] && s4_addr == s2_addr)
            operand = s4_data;
    end

    for (genvar g = 0; g < Tout; g++) begin : g_lane
        psum_lane_add #(.W_PSUM(W_PSUM)) u_add (
            .a   (`PSUM_LANE(operand, g, W_PSUM)),
            .b   (`PSUM_LANE(s2_acc, g, W_PSUM)),
            .sum (`PSUM_LANE(sum_all, g, W_PSUM))
        );
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cfg_w_q  <= '0;
            cfg_h_q  <= '0;
            cfg_q_q  <= '0;
            stg_vld  <= '0;
            s1_addr  <= '0;
            s1_row   <= '0;
            s1_col   <= '0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_final <= 1'b0;
            s1_acc   <= '0;
            s2_addr  <= '0;
            s2_row   <= '0;
            s2_col   <= '0;
            s2_first <= 1'b0;
            s2_last  <= 1'b0;
            s2_final <= 1'b0;
            s2_acc   <= '0;
            s3_addr  <= '0;
            s3_row   <= '0;
            s3_col   <= '0;
            s3_last  <= 1'b0;
            s3_final <= 1'b0;
            s3_data  <= '0;
            s4_addr  <= '0;
            s4_data  <= '0;
        end else begin
            if (i_start) begin
                cfg_w_q <= cfg_width;
                cfg_h_q <= cfg_height;
                cfg_q_q <= cfg_q_channel;
            end
            stg_vld  <= i_start ? '0 : {stg_vld[PSUM_STG-1:0], accept};

            s1_addr  <= BUF_AW'(i_row) * BUF_AW'(cfg_w_q) + BUF_AW'(i_col);
            s1_row   <= i_row;
            s1_col   <= i_col;
            s1_first <= (i_ci_tile == '0);
            s1_last  <= (i_ci_tile == cfg_q_q - W_CHANNEL'(1));
            s1_final <= (i_ci_tile == cfg_q_q - W_CHANNEL'(1)) &&
                        (i_row == cfg_h_q - W_SIZE'(1)) && (i_col == cfg_w_q - W_SIZE'(1));
            s1_acc   <= i_acc;

            s2_addr  <= s1_addr;
            s2_row   <= s1_row;
            s2_col   <= s1_col;
            s2_first <= s1_first;
            s2_last  <= s1_last;
            s2_final <= s1_final;
            s2_acc   <= s1_acc;

            s3_addr  <= s2_addr;
            s3_row   <= s2_row;
            s3_col   <= s2_col;
            s3_last  <= s2_last;
            s3_final <= s2_final;
            s3_data  <= sum_all;

            s4_addr  <= s3_addr;
            s4_data  <= s3_data;
        end
    end

    assign o_pb_rd_req  = stg_vld[0] && !s1_first;
    assign o_pb_rd_addr = s1_addr;
    assign o_pb_wr_en   = stg_vld[2];
    assign o_pb_wr_addr = s3_addr;
    assign o_pb_wr_data = s3_data;
    assign o_out_vld    = stg_vld[2] && s3_last;
    assign o_out_row    = s3_row;
    assign o_out_col    = s3_col;
    assign o_out_data   = s3_data;
    assign o_busy       = (state_q == PS_RUN);
    assign o_frame_done = (state_q == PS_DONE);
    assign o_err        = err_q;
endmodule
